// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows round controller.
// Holds the FSM state enum and the binary-to-decimal digit split helpers.
package bc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_SPLIT,
      S_SCORE,
      S_WIN,
      S_LOSE
   } state_t;

   localparam int MAX_VAL   = 99;
   localparam int WIN_BULLS = 2;
   localparam int DIGIT_W   = 4;

   function automatic logic [DIGIT_W-1:0] tens_of(input logic [7:0] v);
      logic [7:0] q;
      q = v / 8'd10;
      return q[DIGIT_W-1:0];
   endfunction

   function automatic logic [DIGIT_W-1:0] units_of(input logic [7:0] v);
      logic [7:0] r;
      r = v % 8'd10;
      return r[DIGIT_W-1:0];
   endfunction

endpackage

// File: rtl/bulls_cows_game_ctrl_scorer.sv
// Combinational Bulls-and-Cows scorer for two-digit secret and guess.
// Ports: i_sec_t/i_sec_u, i_gue_t/i_gue_u digits in; o_bulls, o_cows out.
module bc_scorer
   import bc_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_sec_t,
   input  logic [DIGIT_W-1:0] i_sec_u,
   input  logic [DIGIT_W-1:0] i_gue_t,
   input  logic [DIGIT_W-1:0] i_gue_u,
   output logic [2:0]         o_bulls,
   output logic [2:0]         o_cows
);

   logic w_bt;
   logic w_bu;
   logic w_ct;
   logic w_cu;

   assign w_bt = (i_gue_t == i_sec_t);
   assign w_bu = (i_gue_u == i_sec_u);

   // A bull on either position removes both that guess digit and that
   // secret digit from cow matching.
   assign w_ct = !w_bt && !w_bu && (i_gue_t == i_sec_u);
   assign w_cu = !w_bu && !w_bt && (i_gue_u == i_sec_t);

   assign o_bulls = {2'b00, w_bt} + {2'b00, w_bu};
   assign o_cows  = {2'b00, w_ct} + {2'b00, w_cu};

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Bulls-and-Cows round controller: secret latch, guess pipeline, scoring.
// Ports: clk/rst, i_set_secret/i_secret_in, i_guess_valid/i_guess_in in;
//   o_guess_ready, o_bulls, o_cows, o_result_valid, o_attempts,
//   o_win, o_lose, o_err out (all registered or state-derived).
module bulls_cows_game_ctrl
   import bc_pkg::*;
#(
   parameter int MAX_TRIES = 8,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set_secret,
   input  logic [7:0]       i_secret_in,
   input  logic             i_guess_valid,
   input  logic [7:0]       i_guess_in,
   output logic             o_guess_ready,
   output logic [2:0]       o_bulls,
   output logic [2:0]       o_cows,
   output logic             o_result_valid,
   output logic [CNT_W-1:0] o_attempts,
   output logic             o_win,
   output logic             o_lose,
   output logic             o_err
);

   state_t r_state;
   state_t w_next;

   logic [DIGIT_W-1:0] r_sec_t, r_sec_u;
   logic [DIGIT_W-1:0] r_gue_t, r_gue_u;
   logic [2:0]         r_bulls, r_cows;
   logic [CNT_W-1:0]   r_att;
   logic               r_rv, r_win, r_lose, r_err;

   logic [DIGIT_W-1:0] w_in_t, w_in_u;
   logic [2:0]         w_bulls, w_cows;
   logic [CNT_W-1:0]   w_att_inc;
   logic               w_sec_ok, w_sec_bad;
   logic               w_guess_take, w_guess_ok, w_guess_bad;

   assign w_in_t = tens_of(i_secret_in);
   assign w_in_u = units_of(i_secret_in);

   assign w_sec_ok  = i_set_secret
                   && (i_secret_in <= 8'(MAX_VAL))
                   && (w_in_t != w_in_u);
   assign w_sec_bad = i_set_secret && !w_sec_ok;

   // A set_secret pulse always swallows a simultaneous guess.
   assign w_guess_take = !i_set_secret && i_guess_valid
                      && (r_state == S_READY);
   assign w_guess_ok   = w_guess_take && (i_guess_in <= 8'(MAX_VAL));
   assign w_guess_bad  = w_guess_take && !w_guess_ok;

   assign w_att_inc = (r_att < CNT_W'(MAX_TRIES)) ? r_att + 1'b1 : r_att;

   bc_scorer u_scorer (
      .i_sec_t (r_sec_t),
      .i_sec_u (r_sec_u),
      .i_gue_t (r_gue_t),
      .i_gue_u (r_gue_u),
      .o_bulls (w_bulls),
      .o_cows  (w_cows)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_sec_ok) begin
         w_next = S_READY;
      end else begin
         case (r_state)
            S_READY: if (w_guess_ok) w_next = S_SPLIT;
            S_SPLIT: w_next = S_SCORE;
            // Verdict flags were registered with the score itself.
            S_SCORE: begin
               if (r_win)       w_next = S_WIN;
               else if (r_lose) w_next = S_LOSE;
               else             w_next = S_READY;
            end
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sec_t <= '0;
         r_sec_u <= '0;
         r_gue_t <= '0;
         r_gue_u <= '0;
         r_bulls <= '0;
         r_cows  <= '0;
         r_att   <= '0;
         r_rv    <= 1'b0;
         r_win   <= 1'b0;
         r_lose  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_rv  <= 1'b0;
         r_err <= w_sec_bad || w_guess_bad;
         if (w_sec_ok) begin
            r_sec_t <= w_in_t;
            r_sec_u <= w_in_u;
            r_bulls <= '0;
            r_cows  <= '0;
            r_att   <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
         end else if (w_guess_ok) begin
            r_gue_t <= tens_of(i_guess_in);
            r_gue_u <= units_of(i_guess_in);
         end else if (r_state == S_SPLIT) begin
            r_bulls <= w_bulls;
            r_cows  <= w_cows;
            r_rv    <= 1'b1;
            r_att   <= w_att_inc;
            r_win   <= (w_bulls == 3'(WIN_BULLS));
            r_lose  <= (w_bulls != 3'(WIN_BULLS))
                    && (w_att_inc == CNT_W'(MAX_TRIES));
         end
      end
   end

   assign o_guess_ready  = (r_state == S_READY);
   assign o_bulls        = r_bulls;
   assign o_cows         = r_cows;
   assign o_result_valid = r_rv;
   assign o_attempts     = r_att;
   assign o_win          = r_win;
   assign o_lose         = r_lose;
   assign o_err          = r_err;

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Bench for bulls_cows_game_ctrl: two instances (8 and 3 tries) share
// one directed stimulus stream and are checked against a round model.
module tb_bulls_cows_game_ctrl;

   localparam int MAXT[2] = '{8, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       ss  = 1'b0;
   logic [7:0] sv  = '0;
   logic       gv  = 1'b0;
   logic [7:0] gi  = '0;

   logic       gr[2];
   logic [2:0] b[2];
   logic [2:0] c[2];
   logic       rv[2];
   logic [3:0] at[2];
   logic       w[2];
   logic       l[2];
   logic       er[2];

   bulls_cows_game_ctrl #(.MAX_TRIES(8), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst),
      .i_set_secret(ss), .i_secret_in(sv),
      .i_guess_valid(gv), .i_guess_in(gi),
      .o_guess_ready(gr[0]), .o_bulls(b[0]), .o_cows(c[0]),
      .o_result_valid(rv[0]), .o_attempts(at[0]),
      .o_win(w[0]), .o_lose(l[0]), .o_err(er[0])
   );

   bulls_cows_game_ctrl #(.MAX_TRIES(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst),
      .i_set_secret(ss), .i_secret_in(sv),
      .i_guess_valid(gv), .i_guess_in(gi),
      .o_guess_ready(gr[1]), .o_bulls(b[1]), .o_cows(c[1]),
      .o_result_valid(rv[1]), .o_attempts(at[1]),
      .o_win(w[1]), .o_lose(l[1]), .o_err(er[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t got=%0d want=%0d",
                  nm, k, $time, act, exp);
      end
   endtask

   // Round model: timeline of accepted guesses and pending results.
   int cyc = 0;
   int m_live[2], m_pend[2], m_open[2];
   int m_att[2], m_b[2], m_c[2], m_w[2], m_l[2];
   int m_rv[2], m_err[2], m_rdy[2];
   int m_s[2][2], m_g[2][2];

   function automatic int accepting(input int k, input int t);
      return int'(m_live[k] != 0 && m_w[k] == 0 && m_l[k] == 0
                  && m_pend[k] < 0 && t >= m_open[k]);
   endfunction

   function automatic void score(input int k);
      int nb, nc;
      nb = 0;
      nc = 0;
      for (int i = 0; i < 2; i++) begin
         if (m_g[k][i] == m_s[k][i]) nb++;
         else if (m_g[k][i] == m_s[k][1-i]
                  && m_g[k][1-i] != m_s[k][1-i]) nc++;
      end
      m_b[k] = nb;
      m_c[k] = nc;
   endfunction

   function automatic void model_step(input int k, input int t);
      int acc;
      acc = accepting(k, t);
      m_rv[k]  = 0;
      m_err[k] = 0;
      if (rst) begin
         m_live[k] = 0; m_pend[k] = -1; m_open[k] = 0;
         m_att[k] = 0; m_b[k] = 0; m_c[k] = 0;
         m_w[k] = 0; m_l[k] = 0;
      end else if (ss && sv <= 99 && (sv / 10) != (sv % 10)) begin
         m_s[k][0] = int'(sv) / 10;
         m_s[k][1] = int'(sv) % 10;
         m_live[k] = 1; m_pend[k] = -1; m_open[k] = t + 1;
         m_att[k] = 0; m_b[k] = 0; m_c[k] = 0;
         m_w[k] = 0; m_l[k] = 0;
      end else begin
         if (ss) m_err[k] = 1;
         if (m_pend[k] == t + 1) begin
            score(k);
            m_rv[k] = 1;
            if (m_att[k] < MAXT[k]) m_att[k]++;
            m_w[k] = int'(m_b[k] == 2);
            m_l[k] = int'(m_w[k] == 0 && m_att[k] == MAXT[k]);
            m_pend[k] = -1;
            m_open[k] = t + 2;
         end
         if (!ss && gv && acc != 0) begin
            if (gi > 99) m_err[k] = 1;
            else begin
               m_g[k][0] = int'(gi) / 10;
               m_g[k][1] = int'(gi) % 10;
               m_pend[k] = t + 2;
            end
         end
      end
      m_rdy[k] = accepting(k, t + 1);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k, cyc);
      cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("ready", k, 32'(gr[k]), m_rdy[k]);
            chk("bulls", k, 32'(b[k]), m_b[k]);
            chk("cows", k, 32'(c[k]), m_c[k]);
            chk("rvalid", k, 32'(rv[k]), m_rv[k]);
            chk("attempts", k, 32'(at[k]), m_att[k]);
            chk("win", k, 32'(w[k]), m_w[k]);
            chk("lose", k, 32'(l[k]), m_l[k]);
            chk("err", k, 32'(er[k]), m_err[k]);
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic [7:0] sval,
                       input logic g, input logic [7:0] gval);
      @(posedge clk);
      #1;
      rst = r; ss = s; sv = sval; gv = g; gi = gval;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic secret(input logic [7:0] v);
      step(1'b0, 1'b1, v, 1'b0, 8'd0);
   endtask

   task automatic guess(input logic [7:0] v);
      step(1'b0, 1'b0, 8'd0, 1'b1, v);
   endtask

   // Guess, then land on the result cycle and pin instance 0 literally.
   task automatic guess_lit(input logic [7:0] v, input int eb, input int ec);
      guess(v);
      idle();
      idle();
      chk("lit_rv", 0, 32'(rv[0]), 1);
      chk("lit_bulls", 0, 32'(b[0]), eb);
      chk("lit_cows", 0, 32'(c[0]), ec);
   endtask

   int g4[4]  = '{12, 41, 74, 77};
   int gb4[4] = '{0, 1, 0, 1};
   int gc4[4] = '{0, 0, 2, 0};

   initial begin
      for (int k = 0; k < 2; k++) m_pend[k] = -1;
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
      chk_en = 1'b1;
      idle();
      chk("lit_rst_att", 0, 32'(at[0]), 0);
      chk("lit_rst_ready", 0, 32'(gr[0]), 0);

      secret(8'd47);
      idle();
      chk("lit_ready", 0, 32'(gr[0]), 1);
      guess_lit(8'd47, 2, 0);
      chk("lit_win", 0, 32'(w[0]), 1);
      chk("lit_att1", 0, 32'(at[0]), 1);
      chk("lit_win_ready", 0, 32'(gr[0]), 0);
      guess(8'd12);
      idle();
      idle();
      chk("lit_win_ignore_rv", 0, 32'(rv[0]), 0);

      secret(8'd47);
      for (int i = 0; i < 4; i++) guess_lit(8'(g4[i]), gb4[i], gc4[i]);
      idle();
      chk("lit_att4", 0, 32'(at[0]), 4);
      chk("lit_ready4", 0, 32'(gr[0]), 1);
      chk("lit_b_lose", 1, 32'(l[1]), 1);
      chk("lit_b_att3", 1, 32'(at[1]), 3);

      secret(8'd58);
      guess_lit(8'd10, 0, 0);
      guess_lit(8'd20, 0, 0);
      guess_lit(8'd30, 0, 0);
      chk("lit_lose3", 1, 32'(l[1]), 1);
      secret(8'd58);
      guess_lit(8'd10, 0, 0);
      guess_lit(8'd20, 0, 0);
      guess_lit(8'd58, 2, 0);
      chk("lit_lastwin_w", 1, 32'(w[1]), 1);
      chk("lit_lastwin_l", 1, 32'(l[1]), 0);

      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
      secret(8'd33);
      idle();
      chk("lit_err33", 0, 32'(er[0]), 1);
      secret(8'd120);
      idle();
      chk("lit_err120", 0, 32'(er[0]), 1);
      chk("lit_idle_ready", 0, 32'(gr[0]), 0);
      secret(8'd12);
      guess(8'd105);
      idle();
      chk("lit_err105", 0, 32'(er[0]), 1);
      chk("lit_att0", 0, 32'(at[0]), 0);

      guess(8'd34);
      guess(8'd12);
      idle();
      chk("lit_split_rv", 0, 32'(rv[0]), 1);
      chk("lit_split_err", 0, 32'(er[0]), 0);
      idle();
      idle();
      chk("lit_split_norv", 0, 32'(rv[0]), 0);

      step(1'b0, 1'b1, 8'd90, 1'b1, 8'd90);
      idle();
      idle();
      chk("lit_same_att", 0, 32'(at[0]), 0);
      chk("lit_same_rv", 0, 32'(rv[0]), 0);

      guess(8'd9);
      secret(8'd12);
      idle();
      chk("lit_mid_rv", 0, 32'(rv[0]), 0);
      chk("lit_mid_att", 0, 32'(at[0]), 0);

      guess(8'd21);
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
      idle();
      chk("lit_rstsplit_rv", 0, 32'(rv[0]), 0);
      chk("lit_rstsplit_ready", 0, 32'(gr[0]), 0);

      secret(8'd12);
      guess_lit(8'd21, 0, 2);
      guess_lit(8'd11, 1, 0);
      guess_lit(8'd22, 1, 0);
      guess_lit(8'd5, 0, 0);
      secret(8'd7);
      guess_lit(8'd70, 0, 2);
      guess_lit(8'd7, 2, 0);
      idle();
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end

endmodule
